param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, giving depth DEPTH = 2**ADDR_WIDTH = 16.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, the almost_full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, the almost_empty threshold (1..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have ports (one clock; reset is asynchronous and active-high):
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous active-high reset
- w_en  input  1  write request
- datain  input  DATA_WIDTH  write data
- r_en  input  1  read request
- dataout  output  DATA_WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  ADDR_WIDTH+1  words stored
- overflow  output  1  one-cycle pulse, write rejected
- underflow  output  1  one-cycle pulse, read rejected

Function
REQ-007 Write SHALL be accepted on a clk edge iff w_en && !full; datain stored at wr_ptr, wr_ptr increments.
REQ-008 Read SHALL be accepted on a clk edge iff r_en && !empty; rd_ptr increments.
REQ-009 Pointers SHALL be ADDR_WIDTH+1 bits; the MSB is the wrap bit; full = (addr bits equal, wrap bits differ); empty = (pointers equal).
REQ-010 count SHALL be +1 on write-only, -1 on read-only, and unchanged on simultaneous accepted read and write.
REQ-011 When full with w_en && r_en asserted, only the read SHALL be accepted, the write SHALL be rejected, and overflow SHALL pulse.
REQ-012 When empty with w_en && r_en asserted, only the write SHALL be accepted, the read SHALL be rejected, and underflow SHALL pulse.
REQ-013 overflow SHALL be registered, high for exactly the cycle after a rejected write, and low otherwise.
REQ-014 underflow SHALL be registered, high for exactly the cycle after a rejected read, and low otherwise.
REQ-015 full, empty, almost_full, almost_empty and count SHALL be registered and reflect the state after the current edge, with no combinational path from w_en or r_en.
REQ-016 With FWFT=0, dataout SHALL update one cycle after an accepted read with the popped word and hold its value otherwise.
REQ-017 With FWFT=1, dataout SHALL present the head word whenever !empty; an accepted read SHALL advance it to the next word on the same edge.
REQ-018 With FWFT=1, the first word written into an empty FIFO SHALL appear on dataout one cycle after the write edge.
REQ-019 Pointer wrap from DEPTH-1 to 0 SHALL toggle the wrap bit and SHALL lose no data.

Reset
REQ-020 On rst assertion, asynchronously: pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, dataout = 0.
REQ-021 Reset mid-operation SHALL discard all contents; memory array contents need not be cleared.
REQ-022 Release of rst SHALL be synchronous to clk; the first accepted write SHALL be on the first clk edge after deassertion.

Structure
REQ-023 Shared package fifo_pkg SHALL hold the default constants (DATA_WIDTH, ADDR_WIDTH) and the pointer-width function.
REQ-024 Storage SHALL be a sub-module fifo_mem: a 2**ADDR_WIDTH x DATA_WIDTH dual-port array with synchronous write and an asynchronous read port.

Verification
REQ-025 Reset, write 16 words 0x01..0x10, then 1 more -> full=1 and count=16 after the 16th write; 17th write: overflow pulses 1 cycle, contents unchanged.
REQ-026 Read 17 times from a full FIFO -> dataout 0x01..0x10 in order; 17th read: underflow pulses, empty=1, count=0.
REQ-027 Simultaneous w_en/r_en at count=5 for 40 cycles -> count stays 5 and pointers wrap at least twice; data order is preserved.
REQ-028 Fill to 14 with AF_LEVEL=14 and AE_LEVEL=2 -> almost_full rises at count 14; on draining, almost_empty rises at count 2.
REQ-029 FWFT=1: write 0xA5 into an empty FIFO -> dataout = 0xA5 next cycle with no r_en; FWFT=0: dataout = 0xA5 one cycle after r_en.
REQ-030 Assert rst mid-burst at count=9 -> empty=1, count=0, dataout=0 immediately; writes after release behave as after first reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port storage array: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered status flags, overflow/underflow pulses
// and a selectable registered-read or first-word-fall-through output.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] dataout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [PW-1:0] AF_C = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C = PW'(AE_LEVEL);

  logic [PW-1:0]         wr_ptr, rd_ptr, wr_next, rd_next, count_next;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Accept decisions use only registered flags, so full/empty never loop back.
  assign wr_ok   = w_en && !full;
  assign rd_ok   = r_en && !empty;
  assign wr_next = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_ok};
  assign rd_next = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_ok};

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)      count_next = count + ONE;
    else if (rd_ok && !wr_ok) count_next = count - ONE;
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (datain),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // Flags are computed from next-state pointers so they describe the FIFO after this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_next;
      rd_ptr       <= rd_next;
      count        <= count_next;
      full         <= (wr_next[ADDR_WIDTH-1:0] == rd_next[ADDR_WIDTH-1:0]) &&
                      (wr_next[ADDR_WIDTH] != rd_next[ADDR_WIDTH]);
      empty        <= (wr_next == rd_next);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      overflow     <= w_en && full;
      underflow    <= r_en && empty;
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is visible straight from the array; zero while nothing is stored.
    assign dataout = empty ? '0 : mem_rdata;
  end else begin : g_registered
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        dataout <= '0;
      else if (rd_ok) dataout <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: registered-read and FWFT instances share stimulus and a queue model.
module tb_param_sync_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] datain = '0;

  logic [DW-1:0] dout0, dout1;
  logic          full0, empty0, af0, ae0, ovf0, udf0;
  logic          full1, empty1, af1, ae1, ovf1, udf1;
  logic [AW:0]   count0, count1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  int            m_count = 0;
  logic [DW-1:0] m_dout0 = '0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    logic [AW:0]   cnt;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          udf;
    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .w_en(w_en), .datain(datain), .r_en(r_en), .dataout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .w_en(w_en), .datain(datain), .r_en(r_en), .dataout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compareAll();
    logic [DW-1:0] head;
    head = (sb.size() > 0) ? sb[0] : '0;
    checkOutput("count0",    32'(count0), 32'(m_count));
    checkOutput("full0",     32'(full0),  32'(m_count == DEPTH));
    checkOutput("empty0",    32'(empty0), 32'(m_count == 0));
    checkOutput("afull0",    32'(af0),    32'(m_count >= 14));
    checkOutput("aempty0",   32'(ae0),    32'(m_count <= 2));
    checkOutput("overflow0", 32'(ovf0),   32'(m_ovf));
    checkOutput("underflow0",32'(udf0),   32'(m_udf));
    checkOutput("dataout0",  32'(dout0),  32'(m_dout0));
    checkOutput("count1",    32'(count1), 32'(m_count));
    checkOutput("full1",     32'(full1),  32'(m_count == DEPTH));
    checkOutput("empty1",    32'(empty1), 32'(m_count == 0));
    checkOutput("afull1",    32'(af1),    32'(m_count >= 14));
    checkOutput("aempty1",   32'(ae1),    32'(m_count <= 2));
    checkOutput("overflow1", 32'(ovf1),   32'(m_ovf));
    checkOutput("underflow1",32'(udf1),   32'(m_udf));
    checkOutput("dataout1",  32'(dout1),  32'(head));
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d);
    logic wr_acc, rd_acc;
    w_en = w;
    r_en = r;
    datain = d;
    wr_acc = w && (m_count < DEPTH);
    rd_acc = r && (m_count > 0);
    @(posedge clk);
    #1;
    m_ovf = w && (m_count == DEPTH);
    m_udf = r && (m_count == 0);
    if (rd_acc) m_dout0 = sb.pop_front();
    if (wr_acc) sb.push_back(d);
    m_count = m_count + int'(wr_acc) - int'(rd_acc);
    w_en = 1'b0;
    r_en = 1'b0;
    compareAll();
  endtask

  // Asserts reset away from a clock edge, checks the asynchronous clear, then releases after the next edge.
  task automatic doReset();
    rst = 1'b1;
    w_en = 1'b0;
    r_en = 1'b0;
    #2;
    sb.delete();
    m_count = 0;
    m_dout0 = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    compareAll();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{w:1'b0, r:1'b1, d:8'h00, cnt:5'd0, full:1'b0, empty:1'b1, ovf:1'b0, udf:1'b1, dout0:8'h00, dout1:8'h00};
    tbl[1] = '{w:1'b1, r:1'b0, d:8'hA5, cnt:5'd1, full:1'b0, empty:1'b0, ovf:1'b0, udf:1'b0, dout0:8'h00, dout1:8'hA5};
    tbl[2] = '{w:1'b0, r:1'b0, d:8'h00, cnt:5'd1, full:1'b0, empty:1'b0, ovf:1'b0, udf:1'b0, dout0:8'h00, dout1:8'hA5};
    tbl[3] = '{w:1'b0, r:1'b1, d:8'h00, cnt:5'd0, full:1'b0, empty:1'b1, ovf:1'b0, udf:1'b0, dout0:8'hA5, dout1:8'h00};
    tbl[4] = '{w:1'b1, r:1'b1, d:8'h3C, cnt:5'd1, full:1'b0, empty:1'b0, ovf:1'b0, udf:1'b1, dout0:8'hA5, dout1:8'h3C};
    tbl[5] = '{w:1'b1, r:1'b1, d:8'h4D, cnt:5'd1, full:1'b0, empty:1'b0, ovf:1'b0, udf:1'b0, dout0:8'h3C, dout1:8'h4D};
    tbl[6] = '{w:1'b0, r:1'b1, d:8'h00, cnt:5'd0, full:1'b0, empty:1'b1, ovf:1'b0, udf:1'b0, dout0:8'h4D, dout1:8'h00};
    tbl[7] = '{w:1'b0, r:1'b0, d:8'h00, cnt:5'd0, full:1'b0, empty:1'b1, ovf:1'b0, udf:1'b0, dout0:8'h4D, dout1:8'h00};

    doReset();

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].w, tbl[i].r, tbl[i].d);
      checkOutput("tbl_count", 32'(count0), 32'(tbl[i].cnt));
      checkOutput("tbl_full",  32'(full0),  32'(tbl[i].full));
      checkOutput("tbl_empty", 32'(empty0), 32'(tbl[i].empty));
      checkOutput("tbl_ovf",   32'(ovf0),   32'(tbl[i].ovf));
      checkOutput("tbl_udf",   32'(udf1),   32'(tbl[i].udf));
      checkOutput("tbl_dout0", 32'(dout0),  32'(tbl[i].dout0));
      checkOutput("tbl_dout1", 32'(dout1),  32'(tbl[i].dout1));
    end

    $display("[TB] fill to full and overflow");
    doReset();
    for (int i = 1; i <= 17; i++) applyStimulus(1'b1, 1'b0, 8'(i));
    checkOutput("fill_full",  32'(full0),  32'd1);
    checkOutput("fill_count", 32'(count0), 32'd16);
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] drain and underflow");
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("drain_order", 32'(dout0), 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("drain_udf", 32'(udf0), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] simultaneous read/write while full");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
    applyStimulus(1'b1, 1'b1, 8'hEE);
    checkOutput("full_rw_ovf", 32'(ovf1), 32'd1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00);

    $display("[TB] steady state at count 5");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 8'($urandom));
    checkOutput("steady_count", 32'(count1), 32'd5);

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'(8'hC0 + i));
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'(8'hD0 + i));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00);

    $display("[TB] random traffic");
    for (int i = 0; i < 150; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
